// File: rtl/regfile_pkg.sv
// Shared constants and read-port types for the 2-read/1-write register file.
// Optional write-through forwarding is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 4;
    localparam int DEFAULT_ADDR_W = 2;

    // Read-port request/response records, sized for the default configuration.
    typedef struct packed {
        logic                      en;
        logic [DEFAULT_ADDR_W-1:0] add;
    } rd_req_t;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] data;
        logic                      valid;
        logic                      miss;
    } rd_resp_t;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Bus bundle for regfile_2r1w: write port, clear, two read ports and the written mask.
// Forwarding behaviour (REGFILE_BYPASS_EN) does not change this interface.
interface regfile_2r1w_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic              write_en;
    logic [ADDR_W-1:0] write_add;
    logic [DATA_W-1:0] data_in;
    logic              clear;

    logic              read_en_a;
    logic [ADDR_W-1:0] read_add_a;
    logic [DATA_W-1:0] data_out_a;
    logic              rd_valid_a;
    logic              rd_miss_a;

    logic              read_en_b;
    logic [ADDR_W-1:0] read_add_b;
    logic [DATA_W-1:0] data_out_b;
    logic              rd_valid_b;
    logic              rd_miss_b;

    logic [DEPTH-1:0]  written_mask;

    modport master (
        output write_en, write_add, data_in, clear,
        output read_en_a, read_add_a, read_en_b, read_add_b,
        input  data_out_a, rd_valid_a, rd_miss_a,
        input  data_out_b, rd_valid_b, rd_miss_b,
        input  written_mask
    );

    modport slave (
        input  write_en, write_add, data_in, clear,
        input  read_en_a, read_add_a, read_en_b, read_add_b,
        output data_out_a, rd_valid_a, rd_miss_a,
        output data_out_b, rd_valid_b, rd_miss_b,
        output written_mask
    );

endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: output data register, valid/miss flags and the forwarding mux.
// Forwarding from the same-cycle write is compiled in only with REGFILE_BYPASS_EN.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_en,
    input  logic [DATA_W-1:0] entry_data,
    input  logic              entry_written,
    input  logic              fwd_hit,
    input  logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              rd_miss
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // fwd_hit already excludes clear cycles, so clear keeps priority over forwarding.
    logic use_fwd;
    assign use_fwd = BYPASS && fwd_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            rd_miss  <= 1'b0;
        end else begin
            rd_valid <= read_en;
            if (read_en) begin
                data_out <= use_fwd ? fwd_data : entry_data;
                rd_miss  <= ~(use_fwd | entry_written);
            end else begin
                rd_miss  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Parametrised register file with one write port, two registered read ports and written tracking.
// Build with REGFILE_BYPASS_EN defined to forward same-cycle writes to matching reads.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_2r1w_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  mask;

    // Clear wins over a same-cycle write; reads in that cycle see pre-clear state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            mask <= '0;
        end else if (bus.clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            mask <= '0;
        end else if (bus.write_en) begin
            mem[bus.write_add]  <= bus.data_in;
            mask[bus.write_add] <= 1'b1;
        end
    end

    assign bus.written_mask = mask;

    logic wr_live;
    logic fwd_hit_a;
    logic fwd_hit_b;

    assign wr_live   = bus.write_en && !bus.clear;
    assign fwd_hit_a = wr_live && (bus.read_add_a == bus.write_add);
    assign fwd_hit_b = wr_live && (bus.read_add_b == bus.write_add);

    regfile_read_port #(.DATA_W(DATA_W)) u_port_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .read_en       (bus.read_en_a),
        .entry_data    (mem[bus.read_add_a]),
        .entry_written (mask[bus.read_add_a]),
        .fwd_hit       (fwd_hit_a),
        .fwd_data      (bus.data_in),
        .data_out      (bus.data_out_a),
        .rd_valid      (bus.rd_valid_a),
        .rd_miss       (bus.rd_miss_a)
    );

    regfile_read_port #(.DATA_W(DATA_W)) u_port_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .read_en       (bus.read_en_b),
        .entry_data    (mem[bus.read_add_b]),
        .entry_written (mask[bus.read_add_b]),
        .fwd_hit       (fwd_hit_b),
        .fwd_data      (bus.data_in),
        .data_out      (bus.data_out_b),
        .rd_valid      (bus.rd_valid_b),
        .rd_miss       (bus.rd_miss_b)
    );

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised register file: one synchronous write port and two independent registered read ports (A, B).
- Successor to the 4x4 single-port register file; generalises data width and depth.
- Adds per-entry written tracking, a synchronous clear and read-valid/miss flags.
- Used as operand storage for the lab datapath, where the ALU reads two operands per cycle.

Parameters:
- DATA_W, 4, width of each entry in bits.
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- write_en  input  1  write strobe
- write_add  input  ADDR_W  write address
- data_in  input  DATA_W  write data
- clear  input  1  synchronous clear of all entries
- read_en_a  input  1  port A read strobe
- read_add_a  input  ADDR_W  port A address
- data_out_a  output  DATA_W  port A registered read data
- rd_valid_a  output  1  port A data valid, one-cycle pulse
- rd_miss_a  output  1  port A entry was never written since reset/clear
- read_en_b, read_add_b, data_out_b, rd_valid_b, rd_miss_b: same as port A, for port B
- written_mask  output  DEPTH  bit i = 1 when entry i holds written data

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, even mid-operation):
  - all entries = 0; written_mask = 0.
  - data_out_a/b = 0; rd_valid_a/b = 0; rd_miss_a/b = 0.
- Write: at posedge with write_en=1 and clear=0, entry[write_add] <= data_in and written_mask[write_add] <= 1.
- Read latency: 1 cycle. At posedge with read_en_x=1:
  - data_out_x <= entry[read_add_x] (0 if unwritten); rd_valid_x <= 1; rd_miss_x <= ~written_mask[read_add_x].
- No read: with read_en_x=0, rd_valid_x <= 0, rd_miss_x <= 0, and data_out_x holds its last value.
- Ports A and B are fully independent. Both may read the same address in the same cycle; both return identical data.
- Same-cycle write and read to the same address (no bypass): read returns the pre-write (old) contents. The new value is visible from the next read onward.
- Clear: at posedge with clear=1, all entries <= 0 and written_mask <= 0.
  - A write in the same cycle is dropped: clear wins.
  - A read in the same cycle returns pre-clear contents and miss status.
- Out-of-range addresses cannot occur (DEPTH is a power of two). Address wrap-around is inherent.
- No X propagation: all storage is reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When write_en=1, clear=0, read_en_x=1 and read_add_x==write_add in the same cycle, data_out_x <= data_in and rd_miss_x <= 0. This applies to each port independently.
- Undefined: the read-old-data behaviour above.
- Clear still has priority in both builds: no forwarding when clear=1.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W constants;
  - a read-port request typedef {en, add};
  - a read-port response typedef {data, valid, miss}.
- One sub-module, regfile_read_port, instantiated twice. It contains the output register, the valid/miss flags and the bypass mux. Storage and written_mask stay in the top.

Test Plan:
- Reset with DATA_W=4, ADDR_W=2; read A add 00 -> data_out_a=0000, rd_valid_a=1, rd_miss_a=1; written_mask=0000.
- Write 0001, 0010, 0011, 0100 to 00..11, then read A=01 and B=10 in the same cycle -> next cycle data_out_a=0010, data_out_b=0011, both valid, no miss; written_mask=1111.
- Write 1110 to 01 while A reads 01 -> data_out_a=0010 (without bypass) or 1110 (REGFILE_BYPASS_EN); the following read returns 1110.
- Assert clear together with a write of 1010 to 11, then read 11 -> data_out=0000, rd_miss=1, written_mask=0000.
- Drop read_en_a after a read of 0100 -> data_out_a holds 0100, rd_valid_a=0 the next cycle.
- Pull rst_n low mid-sequence, between clock edges -> outputs and written_mask go to 0 immediately; a subsequent read of 00 reports a miss.
